// File: rtl/srlzr_tx_sched_if.sv
// Requester / serializer / line bundle for the transmit scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface srlzr_tx_sched_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          ser_load;
    logic [DATA_WIDTH-1:0]         ser_data;
    logic                          ser_shift;
    logic                          ser_bit;
    logic                          tx_line;
    logic                          tx_active;
    logic [GW-1:0]                 grant_id;

    modport master (
        output req_valid, req_data, ser_bit,
        input  req_ready, ser_load, ser_data, ser_shift, tx_line, tx_active, grant_id
    );

    modport slave (
        input  req_valid, req_data, ser_bit,
        output req_ready, ser_load, ser_data, ser_shift, tx_line, tx_active, grant_id
    );
endinterface

// File: rtl/srlzr_tx_sched.sv
// Round-robin transmit scheduler: grants one requester per frame, paces the PISO
// serializer with a baud counter and frames its bits with start/stop on tx_line.
// Optional even parity bit after the data: define SRLZR_TX_SCHED_PARITY_EN.
module srlzr_tx_sched #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    srlzr_tx_sched_if.slave   bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SRLZR_TX_SCHED_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [CW-1:0]   bit_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   ptr_q;
    logic [GW-1:0]   ptr_d;
`ifdef SRLZR_TX_SCHED_PARITY_EN
    logic            parity_q;
`endif

    logic [2*NUM_REQ-1:0]  valid_dbl;
    logic [NUM_REQ-1:0]    valid_rot;
    logic                  any_valid;
    logic [GW-1:0]         pick;
    logic [DATA_WIDTH-1:0] word;
    logic                  grant_now;
    logic                  baud_wrap;
    int                    idx;

    // Rotate so the highest-priority requester sits at bit 0, then take the first hit.
    assign valid_dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
    assign valid_rot = valid_dbl[NUM_REQ-1:0];

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                pick      = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == GW'(k)) word = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign ptr_d = (pick == GW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    // Reset is async, so the grant is gated by it directly rather than by state alone.
    assign grant_now = (state_q == ST_IDLE) && any_valid && !rst;
    assign baud_wrap = (baud_q == BAUD_LAST);

    assign bus.req_ready = grant_now ? (NUM_REQ'(1) << pick) : '0;
    assign bus.ser_load  = grant_now;
    assign bus.ser_data  = grant_now ? word : '0;
    assign bus.ser_shift = (state_q == ST_DATA) && baud_wrap;
    assign bus.tx_active = (state_q != ST_IDLE);
    assign bus.grant_id  = grant_q;

    always_comb begin
        bus.tx_line = 1'b1;
        case (state_q)
            ST_START:  bus.tx_line = 1'b0;
            ST_DATA:   bus.tx_line = bus.ser_bit;
`ifdef SRLZR_TX_SCHED_PARITY_EN
            ST_PARITY: bus.tx_line = parity_q;
`endif
            default:   bus.tx_line = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
`ifdef SRLZR_TX_SCHED_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (state_q == ST_IDLE) begin
            baud_q <= '0;
            bit_q  <= '0;
            if (grant_now) begin
                grant_q  <= pick;
                ptr_q    <= ptr_d;
`ifdef SRLZR_TX_SCHED_PARITY_EN
                parity_q <= ^word;
`endif
                state_q  <= ST_START;
            end
        end else begin
            baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
            if (baud_wrap) begin
                case (state_q)
                    ST_START: state_q <= ST_DATA;
                    ST_DATA: begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
`ifdef SRLZR_TX_SCHED_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
`ifdef SRLZR_TX_SCHED_PARITY_EN
                    ST_PARITY: state_q <= ST_STOP;
`endif
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_srlzr_tx_sched.sv
// Self-checking bench for srlzr_tx_sched: directed cases plus randomized frames
// checked against a frame-level reference model and a round-robin grant model.
module tb_srlzr_tx_sched;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int C  = 4;
`ifdef SRLZR_TX_SCHED_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FRAME = (DW + 2 + NPAR) * C;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   rr_ptr;
    int   last_g;
    int   last_cyc;
    bit   chain;
    logic [DW-1:0] sreg;

    srlzr_tx_sched_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    srlzr_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serializer attached to the scheduler: load a word, shift right, LSB out.
    always @(posedge clk) begin
        if (bus.ser_load)       sreg <= bus.ser_data;
        else if (bus.ser_shift) sreg <= {1'b0, sreg[DW-1:1]};
    end
    assign bus.ser_bit = sreg[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        end
        return -1;
    endfunction

    // Expected line level k cycles after the grant for word w.
    function automatic logic exp_line(input int k, input logic [DW-1:0] w);
        int p;
        p = k / C;
        if (p == 0)                   return 1'b0;
        if (p <= DW)                  return w[p-1];
        if (NPAR == 1 && p == DW + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            check("idle_ready", 32'(bus.req_ready), 32'(0));
            check("idle_load", 32'(bus.ser_load), 32'(0));
            check("idle_data", 32'(bus.ser_data), 32'(0));
            check("idle_line", 32'(bus.tx_line), 32'(1));
            check("idle_active", 32'(bus.tx_active), 32'(0));
            check("idle_gid", 32'(bus.grant_id), 32'(last_g));
        end
        chain = 1'b0;
    endtask

    task automatic do_frame(input logic [N-1:0] v, input logic [N*DW-1:0] d, input int abort_at);
        int g;
        int shifts;
        logic [DW-1:0] w;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data  = d;
        #1;
        g = model_pick(v);
        w = d[g*DW +: DW];
        check("gid_before", 32'(bus.grant_id), 32'(last_g));
        check("grant_ready", 32'(bus.req_ready), 32'(1 << g));
        check("grant_load", 32'(bus.ser_load), 32'(1));
        check("grant_data", 32'(bus.ser_data), 32'(w));
        check("grant_line", 32'(bus.tx_line), 32'(1));
        if (chain) check("grant_spacing", 32'(cyc - last_cyc), 32'(FRAME + 1));
        last_cyc = cyc;
        rr_ptr   = (g + 1) % N;
        last_g   = g;
        shifts   = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            bus.req_valid = N'($urandom);
            #1;
            if (k == abort_at) begin
                #1 rst = 1'b1;
                #1;
                check("abort_line", 32'(bus.tx_line), 32'(1));
                check("abort_active", 32'(bus.tx_active), 32'(0));
                bus.req_valid = '1;
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    #1;
                    check("rst_ready", 32'(bus.req_ready), 32'(0));
                    check("rst_load", 32'(bus.ser_load), 32'(0));
                    check("rst_line", 32'(bus.tx_line), 32'(1));
                end
                @(negedge clk);
                bus.req_valid = '0;
                rst    = 1'b0;
                rr_ptr = 0;
                last_g = 0;
                chain  = 1'b0;
                return;
            end
            check("frame_line", 32'(bus.tx_line), 32'(exp_line(k, w)));
            check("frame_active", 32'(bus.tx_active), 32'(1));
            check("frame_shift", 32'(bus.ser_shift),
                  32'((k / C >= 1 && k / C <= DW && k % C == C - 1) ? 1 : 0));
            check("frame_noready", 32'({bus.req_ready, bus.ser_load}), 32'(0));
            check("frame_gid", 32'(bus.grant_id), 32'(g));
            shifts += int'(bus.ser_shift);
        end
        check("shift_count", 32'(shifts), 32'(DW));
        chain = 1'b1;
    endtask

    initial begin
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        n_checks = 0;
        n_errors = 0;
        rr_ptr   = 0;
        last_g   = 0;
        last_cyc = 0;
        chain    = 1'b0;
        rst      = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_line", 32'(bus.tx_line), 32'(1));
        check("reset_active", 32'(bus.tx_active), 32'(0));
        check("reset_ready", 32'(bus.req_ready), 32'(0));
        check("reset_load", 32'(bus.ser_load), 32'(0));
        check("reset_shift", 32'(bus.ser_shift), 32'(0));
        check("reset_gid", 32'(bus.grant_id), 32'(0));
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b0;
        idle(2);

        do_frame(2'b01, {8'h22, 8'hA5}, -1);
        idle(1);
        for (int i = 0; i < 4; i++) do_frame(2'b11, {8'h22, 8'h11}, -1);
        do_frame(2'b10, {8'h22, 8'h11}, -1);
        do_frame(2'b01, {8'h22, 8'h07}, -1);
        do_frame(2'b11, {8'h3C, 8'hC3}, 4 * C + 1);
        idle(3);

        for (int i = 0; i < 20; i++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            d = (N*DW)'({$urandom, $urandom});
            do_frame(v, d, -1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/srlzr_tx_sched.md
Name: srlzr_tx_sched

Overview:
Transmit scheduler for the PISO serializer. It arbitrates round-robin between NUM_REQ byte requesters and loads the granted word into the serializer. It times each bit with an internal baud counter and pulses the serializer's shift input. It frames the serial stream with start/stop bits onto tx_line, sitting between the parallel requester logic and the line output of the transceiver.

Parameters:
NUM_REQ, 2, number of requester channels (>=1)
DATA_WIDTH, 8, word width shared with the serializer
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_WIDTH  packed words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[k]&req_ready[k]
ser_load  out  1  one-cycle load strobe to serializer
ser_data  out  DATA_WIDTH  word presented with ser_load
ser_shift  out  1  one-cycle shift strobe to serializer
ser_bit  in  1  serializer serial output (current LSB)
tx_line  out  1  framed serial line, idle high
tx_active  out  1  high while a frame is on the line
grant_id  out  max(1,$clog2(NUM_REQ))  index of last granted requester

Behaviour:
- Reset (async, immediate): state=IDLE; tx_line=1, tx_active=0, ser_load=0, ser_shift=0, req_ready=0, grant_id=0, baud/bit counters=0. The round-robin pointer is set so requester 0 has top priority.
- States: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP when the optional feature is enabled).
- IDLE: tx_line=1, tx_active=0.
  - If any req_valid: pick g = first asserted index searching upward (wrapping) from grant_id+1 (from 0 after reset).
  - Same cycle, combinational: req_ready=1<<g, ser_load=1, ser_data=req_data[g].
  - Register grant_id<=g; next state START.
  - No req_valid: req_ready=0, ser_load=0, ser_data=0.
- START: tx_line=0, tx_active=1 for exactly CLKS_PER_BIT cycles.
- DATA: tx_line=ser_bit, LSB first, DATA_WIDTH bit periods of CLKS_PER_BIT cycles each.
  - ser_shift=1 on the last cycle of every data bit period (DATA_WIDTH pulses total).
- STOP: tx_line=1, tx_active=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency/throughput:
  - tx_line falls on the cycle after the grant.
  - Frame = (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - At least 1 IDLE cycle between frames, so back-to-back grants are spaced frame+1 cycles apart.
- req_valid changes during a frame are ignored; no grant outside IDLE, req_ready is 0 outside IDLE.
- Only one requester is granted per IDLE cycle. Single-requester config (NUM_REQ=1) always grants 0.
- Reset mid-frame: line returns high asynchronously, the frame is aborted, and no grant is issued until reset is released.
- Counters: baud counter counts 0..CLKS_PER_BIT-1 and wraps; bit counter counts 0..DATA_WIDTH-1. No overflow beyond these ranges.

Optional Feature:
SRLZR_TX_SCHED_PARITY_EN
- Defined: even-parity bit p=^word is captured at grant. A PARITY state (tx_line=p for CLKS_PER_BIT cycles) is inserted after DATA, and the frame becomes (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
- Undefined: no parity state or parity register; frame as above.

Test Plan:
- Reset, CLKS_PER_BIT=4, req_valid=01, data0=0xA5 (serializer model attached) -> req_ready=01 and ser_load for 1 cycle. Line reads 0, then 1,0,1,0,0,1,0,1 (each 4 cycles), then 1 for 4 cycles; tx_active high 40 cycles; 8 ser_shift pulses.
- req_valid=11 held continuously, data0=0x11, data1=0x22 -> grants alternate 0,1,0,1. grant_id follows; successive ser_load strobes 41 cycles apart.
- req_valid=10 only -> requester 1 granted, ser_data=0x22, req_ready=10, grant_id=1.
- rst asserted during bit 3 of a frame -> tx_line=1, tx_active=0 without waiting for a clock edge. After release with req_valid=00, the block stays IDLE.
- req_valid toggled during DATA -> no req_ready or ser_load until the IDLE cycle following STOP.
- With SRLZR_TX_SCHED_PARITY_EN, data=0x07 -> parity bit 1 after bit 7; frame 44 cycles at CLKS_PER_BIT=4.
